// File: rtl/matrix_pkg.sv
// Shared types and helpers for the element-wise matrix engine.
package matrix_pkg;

    localparam int unsigned DEF_MAX_DIM = 5;
    localparam int unsigned DEF_DATA_W  = 8;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_SMUL = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_RUN   = 2'b10
    } state_e;

    // Bit offset of element (r,c) in a flattened MAX_DIM x MAX_DIM matrix
    function automatic int unsigned elem_off(input int unsigned r, input int unsigned c,
                                             input int unsigned max_dim, input int unsigned data_w);
        return (r * max_dim + c) * data_w;
    endfunction

endpackage

// File: rtl/matrix_elem_alu.sv
// Single-element add / subtract / scalar-multiply with optional saturation.
module matrix_elem_alu
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int          SATURATE = 0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] scalar,
    input  mode_e             mode,
    output logic [DATA_W-1:0] res_c
);

    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] prod;

    // Widened arithmetic, then wrap or clamp back to DATA_W
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        prod  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, scalar};
        res_c = '0;
        case (mode)
            MODE_ADD:  res_c = (SATURATE != 0 && sum[DATA_W]) ? '1 : sum[DATA_W-1:0];
            MODE_SUB:  res_c = (SATURATE != 0 && diff[DATA_W]) ? '0 : diff[DATA_W-1:0];
            MODE_SMUL: res_c = (SATURATE != 0 && (|prod[2*DATA_W-1:DATA_W])) ? '1 : prod[DATA_W-1:0];
            default:   res_c = '0;
        endcase
    end

endmodule

// File: rtl/matrix_elem_unit.sv
// Sequential element-wise matrix engine: one element per cycle after a dimension check.
module matrix_elem_unit
    import matrix_pkg::*;
#(
    parameter int unsigned MAX_DIM  = DEF_MAX_DIM,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int          SATURATE = 0,
    localparam int unsigned DIM_W   = $clog2(MAX_DIM + 1),
    localparam int unsigned MW      = MAX_DIM * MAX_DIM * DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DIM_W-1:0]  m,
    input  logic [DIM_W-1:0]  n,
    input  logic [DIM_W-1:0]  mB,
    input  logic [DIM_W-1:0]  nB,
    input  logic [DATA_W-1:0] scalar,
    input  logic [MW-1:0]     matrixA,
    input  logic [MW-1:0]     matrixB,
    output logic [MW-1:0]     result,
    output logic              busy,
    output logic              valid,
    output logic              opError
);

    localparam int unsigned IDX_W = $clog2(MW);

    state_e            state_q, state_d;
    logic [DIM_W-1:0]  r_q, r_d, c_q, c_d;
    logic              busy_q, busy_d, valid_q, valid_d, err_q, err_d;
    logic              accept, wr_en, req_err;
    mode_e             mode_q;
    logic [DIM_W-1:0]  m_q, n_q, mb_q, nb_q;
    logic [DATA_W-1:0] scalar_q;
    logic [MW-1:0]     a_q, b_q, result_q;
    logic [IDX_W-1:0]  off;
    logic [DATA_W-1:0] alu_res;

    // Validity of the latched request
    always_comb begin
        req_err = (m_q == '0) || (m_q > DIM_W'(MAX_DIM)) ||
                  (n_q == '0) || (n_q > DIM_W'(MAX_DIM)) ||
                  (mode_q == MODE_RSVD) ||
                  (((mode_q == MODE_ADD) || (mode_q == MODE_SUB)) &&
                   ((mb_q != m_q) || (nb_q != n_q)));
        off     = IDX_W'(elem_off(32'(r_q), 32'(c_q), MAX_DIM, DATA_W));
    end

    matrix_elem_alu #(
        .DATA_W   (DATA_W),
        .SATURATE (SATURATE)
    ) u_alu (
        .a      (a_q[off +: DATA_W]),
        .b      (b_q[off +: DATA_W]),
        .scalar (scalar_q),
        .mode   (mode_q),
        .res_c  (alu_res)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state, counter and status decisions
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        err_d   = err_q;
        accept  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (req_err) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    r_d     = '0;
                    c_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_en = 1'b1;
                if (c_q == n_q - DIM_W'(1)) begin
                    c_d = '0;
                    r_d = r_q + DIM_W'(1);
                    if (r_q == m_q - DIM_W'(1)) begin
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    c_d = c_q + DIM_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, status flags, operand latches and result register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q      <= '0;
            c_q      <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            mode_q   <= MODE_ADD;
            m_q      <= '0;
            n_q      <= '0;
            mb_q     <= '0;
            nb_q     <= '0;
            scalar_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            r_q     <= r_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            if (accept) begin
                mode_q   <= mode_e'(mode);
                m_q      <= m;
                n_q      <= n;
                mb_q     <= mB;
                nb_q     <= nB;
                scalar_q <= scalar;
                a_q      <= matrixA;
                b_q      <= matrixB;
                result_q <= '0;
            end
            if (wr_en) result_q[off +: DATA_W] <= alu_res;
        end
    end

    assign result  = result_q;
    assign busy    = busy_q;
    assign valid   = valid_q;
    assign opError = err_q;

endmodule

// File: tb/tb_matrix_elem_unit.sv
// Directed bench for matrix_elem_unit, wrapping and saturating instances side by side.
module tb_matrix_elem_unit;

    localparam int unsigned MAX_DIM = 5;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DIM_W   = 3;
    localparam int unsigned MW      = MAX_DIM * MAX_DIM * DATA_W;

    logic              clk = 1'b0;
    logic              reset, start;
    logic [1:0]        mode;
    logic [DIM_W-1:0]  m, n, mb, nb;
    logic [DATA_W-1:0] scalar;
    logic [MW-1:0]     a_v, b_v, res_w, res_s, exp_w, exp_s, exp_p;
    logic              busy_w, busy_s, valid_w, valid_s, err_w, err_s;
    int                total = 0;
    int                bad   = 0;
    int                lat;

    always #5 clk = ~clk;

    matrix_elem_unit #(.MAX_DIM(MAX_DIM), .DATA_W(DATA_W), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .m(m), .n(n),
        .mB(mb), .nB(nb), .scalar(scalar), .matrixA(a_v), .matrixB(b_v),
        .result(res_w), .busy(busy_w), .valid(valid_w), .opError(err_w)
    );

    matrix_elem_unit #(.MAX_DIM(MAX_DIM), .DATA_W(DATA_W), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .m(m), .n(n),
        .mB(mb), .nB(nb), .scalar(scalar), .matrixA(a_v), .matrixB(b_v),
        .result(res_s), .busy(busy_s), .valid(valid_s), .opError(err_s)
    );

    task automatic check_int(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_vec(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [MW-1:0] setel(input logic [MW-1:0] v, input int r, input int c,
                                            input logic [DATA_W-1:0] x);
        logic [7:0] idx;
        idx = 8'((r * MAX_DIM + c) * DATA_W);
        v[idx +: DATA_W] = x;
        return v;
    endfunction

    function automatic logic [MW-1:0] fill(input logic [DATA_W-1:0] x);
        logic [MW-1:0] v;
        v = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                v = setel(v, i, j, x);
        return v;
    endfunction

    task automatic set_req(input logic [1:0] md, input int mm, input int nn, input int mbb,
                           input int nbb, input logic [DATA_W-1:0] sc);
        mode   = md;
        m      = DIM_W'(mm);
        n      = DIM_W'(nn);
        mb     = DIM_W'(mbb);
        nb     = DIM_W'(nbb);
        scalar = sc;
    endtask

    task automatic wait_idle(input int lat_in, output int lat_out);
        int l;
        l = lat_in;
        while (busy_w && l < 100) begin
            @(posedge clk);
            l++;
            @(negedge clk);
        end
        check_int("busy_timeout", int'(busy_w), 0);
        lat_out = l;
    endtask

    task automatic run_op(output int lat_out);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_int("busy_accept", int'(busy_w), 1);
        wait_idle(0, lat_out);
    endtask

    task automatic check_done(input string tag, input int l, input int exp_lat, input int ev,
                              input int ee, input logic [MW-1:0] ew, input logic [MW-1:0] es);
        check_int({tag, "_lat"}, l, exp_lat);
        check_int({tag, "_valid_w"}, int'(valid_w), ev);
        check_int({tag, "_err_w"}, int'(err_w), ee);
        check_int({tag, "_valid_s"}, int'(valid_s), ev);
        check_int({tag, "_err_s"}, int'(err_s), ee);
        check_int({tag, "_busy_s"}, int'(busy_s), 0);
        check_vec({tag, "_res_w"}, res_w, ew);
        check_vec({tag, "_res_s"}, res_s, es);
    endtask

    task automatic load_add23();
        a_v = '0;
        a_v = setel(a_v, 0, 0, 8'd1); a_v = setel(a_v, 0, 1, 8'd2); a_v = setel(a_v, 0, 2, 8'd3);
        a_v = setel(a_v, 1, 0, 8'd3); a_v = setel(a_v, 1, 1, 8'd4); a_v = setel(a_v, 1, 2, 8'd5);
        b_v = '0;
        b_v = setel(b_v, 0, 0, 8'd3); b_v = setel(b_v, 0, 1, 8'd3); b_v = setel(b_v, 0, 2, 8'd3);
        b_v = setel(b_v, 1, 0, 8'd2); b_v = setel(b_v, 1, 1, 8'd2); b_v = setel(b_v, 1, 2, 8'd2);
        set_req(2'b00, 2, 3, 2, 3, 8'd0);
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        a_v    = '0;
        b_v    = '0;
        set_req(2'b00, 0, 0, 0, 0, 8'd0);
        repeat (2) @(negedge clk);
        check_int("rst_busy", int'(busy_w), 0);
        check_int("rst_valid", int'(valid_w), 0);
        check_int("rst_err", int'(err_w), 0);
        check_vec("rst_res", res_w, '0);
        reset = 1'b1;
        @(negedge clk);

        // 2x3 add
        exp_w = '0;
        exp_w = setel(exp_w, 0, 0, 8'd4); exp_w = setel(exp_w, 0, 1, 8'd5); exp_w = setel(exp_w, 0, 2, 8'd6);
        exp_w = setel(exp_w, 1, 0, 8'd5); exp_w = setel(exp_w, 1, 1, 8'd6); exp_w = setel(exp_w, 1, 2, 8'd7);
        load_add23();
        run_op(lat);
        check_done("add23", lat, 7, 1, 0, exp_w, exp_w);

        // rejected requests: B shape mismatch, reserved mode, zero rows
        set_req(2'b01, 2, 2, 3, 2, 8'd0);
        run_op(lat);
        check_done("sub_dim", lat, 1, 0, 1, '0, '0);
        set_req(2'b11, 2, 2, 2, 2, 8'd0);
        run_op(lat);
        check_done("rsvd", lat, 1, 0, 1, '0, '0);
        set_req(2'b00, 0, 2, 0, 2, 8'd0);
        run_op(lat);
        check_done("m_zero", lat, 1, 0, 1, '0, '0);

        // 1x1 add overflow: 300 wraps to 44, clamps to 255
        a_v = setel('0, 0, 0, 8'd200);
        b_v = setel('0, 0, 0, 8'd100);
        set_req(2'b00, 1, 1, 1, 1, 8'd0);
        run_op(lat);
        check_done("add_ovf", lat, 2, 1, 0, setel('0, 0, 0, 8'd44), setel('0, 0, 0, 8'd255));

        // 1x1 sub underflow: 3-5 wraps to 254, clamps to 0
        a_v = setel('0, 0, 0, 8'd3);
        b_v = setel('0, 0, 0, 8'd5);
        set_req(2'b01, 1, 1, 1, 1, 8'd0);
        run_op(lat);
        check_done("sub_unf", lat, 2, 1, 0, setel('0, 0, 0, 8'd254), '0);

        // 5x5 scalar multiply, B shape ignored
        a_v = fill(8'd3);
        b_v = '0;
        set_req(2'b10, 5, 5, 0, 0, 8'd4);
        run_op(lat);
        check_done("smul4", lat, 26, 1, 0, fill(8'd12), fill(8'd12));
        set_req(2'b10, 5, 5, 0, 0, 8'd100);
        run_op(lat);
        check_done("smul100", lat, 26, 1, 0, fill(8'd44), fill(8'd255));

        // start pulsed mid-RUN with different operands is ignored
        load_add23();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        repeat (3) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        a_v = fill(8'd7);
        set_req(2'b10, 5, 5, 0, 0, 8'd9);
        start = 1'b1;
        @(posedge clk);
        lat++;
        @(negedge clk);
        start = 1'b0;
        wait_idle(lat, lat);
        check_done("restart", lat, 7, 1, 0, exp_w, exp_w);

        // reset at the third RUN cycle aborts the operation
        load_add23();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_p = setel('0, 0, 0, 8'd4);
        exp_p = setel(exp_p, 0, 1, 8'd5);
        check_vec("partial_res", res_w, exp_p);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_int("abort_busy", int'(busy_w), 0);
        check_int("abort_valid", int'(valid_w), 0);
        check_int("abort_err", int'(err_w), 0);
        check_vec("abort_res", res_w, '0);
        reset = 1'b1;
        @(negedge clk);
        run_op(lat);
        check_done("after_abort", lat, 7, 1, 0, exp_w, exp_w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
